four_bit_alu: RTL and testbench

- 4-bit MIPS-style ALU slice providing AND, OR, ADD, SUB and SLT.
- Provides carry-lookahead group generate/propagate outputs (G, P) so slices can feed a CLA unit in a wider ALU.
- Also provides set (SLT sign source), overflow and zero flags.
- Combinational datapath; all outputs registered on one clock.

---
 rtl/four_bit_alu.sv | 128 ++++++++++++
 tb/tb_four_bit_alu.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/four_bit_alu.sv
// ---------------------------------------------------------------------------
// four_bit_alu
//
// 4-bit MIPS-style ALU slice: AND, OR, ADD, SUB and SLT. Exposes group
// generate/propagate (G, P) so several slices can hang off a carry-lookahead
// unit. The datapath is combinational and every output is registered, giving
// one cycle of latency with a new operation accepted every cycle.
//
// Ports:
//   clk       in   1  system clock, rising edge
//   reset     in   1  synchronous, active-high reset
//   a, b      in   4  operands
//   cin       in   1  carry into bit 0 (forced to 1 when op[2] inverts b)
//   less      in   1  SLT input, routed to result[0] for op 111
//   op        in   3  op[2] = binvert, op[1:0] = function select
//   result    out  4  registered result
//   cout      out  1  registered carry out of bit 3
//   G, P      out  1  registered group generate / propagate
//   set       out  1  registered adder sum bit 3 (SLT sign source)
//   overflow  out  1  registered signed overflow
//   zero      out  1  registered, 1 when result == 0
//
// Optional feature: define ALU_NOR_EN to make op 011 return ~(a | b).
// Without it op 011 returns 0000. Adder-derived outputs are identical in
// both builds.
// ---------------------------------------------------------------------------
module four_bit_alu (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    input  logic       less,
    input  logic [2:0] op,
    output logic [3:0] result,
    output logic       cout,
    output logic       G,
    output logic       P,
    output logic       set,
    output logic       overflow,
    output logic       zero
);

    // Combinational adder/lookahead terms
    logic [3:0] bb;
    logic       ci;
    logic [4:0] sum;
    logic [3:0] g;
    logic [3:0] p;
    logic       c3;

    // Next-state and registered copies of every output
    logic [3:0] result_d, result_q;
    logic       cout_d, cout_q;
    logic       g_grp_d, g_grp_q;
    logic       p_grp_d, p_grp_q;
    logic       set_d, set_q;
    logic       overflow_d, overflow_q;
    logic       zero_d, zero_q;

    assign bb  = op[2] ? ~b : b;
    // Subtract supplies its own +1 for the two's complement of b.
    assign ci  = cin | op[2];
    assign sum = {1'b0, a} + {1'b0, bb} + {4'b0000, ci};
    assign g   = a & bb;
    assign p   = a | bb;

    // Carry into bit 3, taken from the lookahead terms so that the ripple
    // sum above stays a single adder.
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) |
                (p[2] & p[1] & p[0] & ci);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // through the case can leave it unassigned and infer a latch.
        result_d = 4'b0000;
        unique case (op)
            3'b000, 3'b100: result_d = a & bb;
            3'b001, 3'b101: result_d = a | bb;
            3'b010, 3'b110: result_d = sum[3:0];
            3'b111:         result_d = {3'b000, less};
`ifdef ALU_NOR_EN
            3'b011:         result_d = ~(a | b);
`else
            3'b011:         result_d = 4'b0000;
`endif
        endcase

        cout_d     = sum[4];
        g_grp_d    = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) |
                     (p[3] & p[2] & p[1] & g[0]);
        p_grp_d    = &p;
        set_d      = sum[3];
        overflow_d = c3 ^ sum[4];
        zero_d     = (result_d == 4'b0000);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge value of its inputs, independent of statement order.
        if (reset) begin
            result_q   <= 4'b0000;
            cout_q     <= 1'b0;
            g_grp_q    <= 1'b0;
            p_grp_q    <= 1'b0;
            set_q      <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b1;
        end else begin
            result_q   <= result_d;
            cout_q     <= cout_d;
            g_grp_q    <= g_grp_d;
            p_grp_q    <= p_grp_d;
            set_q      <= set_d;
            overflow_q <= overflow_d;
            zero_q     <= zero_d;
        end
    end

    assign result   = result_q;
    assign cout     = cout_q;
    assign G        = g_grp_q;
    assign P        = p_grp_q;
    assign set      = set_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_four_bit_alu.sv
// ---------------------------------------------------------------------------
// tb_four_bit_alu
//
// Directed plus randomized stimulus for four_bit_alu. Each driven operation
// pushes its expected outputs (from an arithmetic reference model) onto a
// scoreboard queue; after the capturing clock edge the entry is popped and
// compared field by field with immediate assertions.
// ---------------------------------------------------------------------------
module tb_four_bit_alu;

    typedef struct packed {
        logic [3:0] result;
        logic       cout;
        logic       g;
        logic       p;
        logic       set;
        logic       overflow;
        logic       zero;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       less;
    logic [2:0] op;
    logic [3:0] result;
    logic       cout;
    logic       G;
    logic       P;
    logic       set;
    logic       overflow;
    logic       zero;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    four_bit_alu dut (
        .clk      (clk),
        .reset    (reset),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .less     (less),
        .op       (op),
        .result   (result),
        .cout     (cout),
        .G        (G),
        .P        (P),
        .set      (set),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic, signed-overflow rule on
    // operand/sum signs, group generate as the carry of a + bb with no cin.
    function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb,
                                   input logic mcin, input logic mless,
                                   input logic [2:0] mop, input logic mrst);
        exp_t       e;
        logic [3:0] mbb;
        logic [4:0] s;
        logic [4:0] gsum;
        if (mrst) begin
            e = '0;
            e.zero = 1'b1;
            return e;
        end
        mbb  = mop[2] ? ~mb : mb;
        s    = 5'(ma) + 5'(mbb) + 5'(mcin | mop[2]);
        gsum = 5'(ma) + 5'(mbb);
        case (mop)
            3'b000, 3'b100: e.result = ma & mbb;
            3'b001, 3'b101: e.result = ma | mbb;
            3'b010, 3'b110: e.result = s[3:0];
            3'b111:         e.result = {3'b000, mless};
`ifdef ALU_NOR_EN
            3'b011:         e.result = ~(ma | mb);
`endif
            default:        e.result = 4'b0000;
        endcase
        e.cout     = s[4];
        e.g        = gsum[4];
        e.p        = ((ma | mbb) == 4'hF);
        e.set      = s[3];
        e.overflow = (ma[3] == mbb[3]) && (s[3] != ma[3]);
        e.zero     = (e.result == 4'b0000);
        return e;
    endfunction

    task automatic check(input string tag, input logic [3:0] obs,
                         input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %b expected %b", tag, obs, expv);
        end
    endtask

    // Drive one operation, push its expectation, clock it in, then pop and
    // compare 1 ns after the capturing edge.
    task automatic step(input string tag, input logic [3:0] sa,
                        input logic [3:0] sb, input logic scin,
                        input logic sless, input logic [2:0] sop,
                        input logic srst);
        exp_t e;
        reset = srst;
        a     = sa;
        b     = sb;
        cin   = scin;
        less  = sless;
        op    = sop;
        sb_q.push_back(model(sa, sb, scin, sless, sop, srst));
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s: scoreboard empty got 1 expected 0", tag);
            return;
        end
        e = sb_q.pop_front();
        check({tag, ".result"},   result,          e.result);
        check({tag, ".cout"},     {3'b000, cout},     {3'b000, e.cout});
        check({tag, ".G"},        {3'b000, G},        {3'b000, e.g});
        check({tag, ".P"},        {3'b000, P},        {3'b000, e.p});
        check({tag, ".set"},      {3'b000, set},      {3'b000, e.set});
        check({tag, ".overflow"}, {3'b000, overflow}, {3'b000, e.overflow});
        check({tag, ".zero"},     {3'b000, zero},     {3'b000, e.zero});
    endtask

    initial begin
        reset = 1'b1;
        a = '0; b = '0; cin = 1'b0; less = 1'b0; op = '0;
        #2;

        // Reset state with non-zero operands on the inputs
        step("reset_init", 4'b1111, 4'b1111, 1'b1, 1'b1, 3'b010, 1'b1);

        // Spot checks against hand-derived constants
        step("add_1_1", 4'b0001, 4'b0001, 1'b0, 1'b0, 3'b010, 1'b0);
        check("add_1_1.const_result", result, 4'd2);
        check("add_1_1.const_gp", {2'b00, G, P}, 4'b0000);

        step("sub_4_1", 4'b0100, 4'b0001, 1'b0, 1'b0, 3'b110, 1'b0);
        check("sub_4_1.const_result", result, 4'd3);
        check("sub_4_1.const_cgp", {1'b0, cout, G, P}, 4'b0110);

        step("ovf_7_1", 4'b0111, 4'b0001, 1'b0, 1'b0, 3'b010, 1'b0);
        check("ovf_7_1.const", {set, overflow, cout, zero}, 4'b1100);

        step("slt_less1", 4'b0010, 4'b0101, 1'b0, 1'b1, 3'b111, 1'b0);
        check("slt_less1.const", {result[0], set, zero, 1'b0}, 4'b1100);
        step("slt_less0", 4'b0010, 4'b0101, 1'b0, 1'b0, 3'b111, 1'b0);
        check("slt_less0.const", {result[0], zero, 2'b00}, 4'b0100);

        step("and_zero", 4'b1010, 4'b0101, 1'b0, 1'b0, 3'b000, 1'b0);
        check("and_zero.const", {3'b000, zero}, 4'b0001);
        step("or_full", 4'b1010, 4'b0101, 1'b0, 1'b0, 3'b001, 1'b0);
        check("or_full.const", result, 4'b1111);
        step("op011", 4'b1010, 4'b0101, 1'b0, 1'b0, 3'b011, 1'b0);
        check("op011.const", {result[2:0], zero}, 4'b0001);

        // binverted logic ops and add with cin
        step("andn", 4'b1100, 4'b1010, 1'b0, 1'b0, 3'b100, 1'b0);
        step("orn", 4'b0000, 4'b1010, 1'b1, 1'b0, 3'b101, 1'b0);
        step("add_cin", 4'b1111, 4'b0000, 1'b1, 1'b0, 3'b010, 1'b0);
        step("sub_neg_ovf", 4'b1000, 4'b0001, 1'b0, 1'b0, 3'b110, 1'b0);

        // Reset mid-stream discards the SUB, release shows it next edge
        step("reset_mid", 4'b0100, 4'b0001, 1'b0, 1'b0, 3'b110, 1'b1);
        step("sub_after_rst", 4'b0100, 4'b0001, 1'b0, 1'b0, 3'b110, 1'b0);
        check("sub_after_rst.const", result, 4'd3);

        // Random sweep across all ops
        for (int i = 0; i < 40; i++) begin
            step("rand", 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 3'($urandom_range(0, 7)), 1'(i == 20));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
